unrot_seq: RTL and testbench
============================

# unrot_seq

Sequential inverse of the combinational barrel rotator. It rotates an N-bit word left by k, so that out[i] = in[(i+k) mod N], which exactly undoes the right-rotate out[i] = in[(i−k) mod N]. The block processes one binary stage per clock under a valid/ready handshake on both sides, which trades latency for area. It sits downstream of the rotator in the permutation datapath and restores original bit order.

## Interface
- N, 512: word width; must be a power of two, N ≥ 2.
- log2_N, 9: log2(N); sizes k and the stage counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word and k are valid.
- in_ready  out  1  block can accept a job; high only in IDLE.
- in_bits  in  [0:N-1]  word to un-rotate; index 0 is leftmost.
- in_k  in  [0:log2_N-1]  rotate amount; k[0] is the MSB, so stage s has weight N>>(s+1).
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  downstream accepts the result.
- out_bits  out  [0:N-1]  un-rotated word.

## Operation
- States: IDLE, SHIFT, DONE. State encoding lives in the package.
- Registers: data[0:N-1], kreg[0:log2_N-1], cnt (stage index), state.
- IDLE: in_ready=1.
  - On in_valid, load data←in_bits and kreg←in_k, set cnt←0, go to SHIFT.
- SHIFT: each edge applies stage cnt.
  - If kreg[cnt]=1: data[i]←data[(i + (N>>(cnt+1))) mod N].
  - If kreg[cnt]=0: data is unchanged.
  - cnt←cnt+1. The edge that processes cnt = log2_N−1 goes to DONE.
- DONE: out_valid=1, out_bits=data.
  - If out_ready=1, go to IDLE.
  - If out_ready=0, hold; out_bits stays stable.
- out_bits is driven from data in every state, but is meaningful only when out_valid=1.
- Index arithmetic is modulo N and done at elaboration. Shift amounts are constants per stage, selected by cnt. No runtime adder on data.
- Composition: the result equals a left rotate by the unsigned value of kreg. rot(x,k) followed by unrot_seq(·,k) returns x for every k.
- in_valid outside IDLE is ignored; in_ready=0 there, so no job is lost or overwritten.
- out_ready outside DONE is ignored.

## Timing
- Reset (asynchronous, rst_n=0):
  - state=IDLE, cnt=0, data=0, kreg=0.
  - in_ready=1, out_valid=0, out_bits=0.
- Reset mid-SHIFT or mid-DONE aborts the job. No output is produced for it.
- Acceptance edge E0, meaning in_valid && in_ready is sampled.
  - Base build: out_valid rises after edge E0+log2_N, independent of k (k=0 included).
- Minimum job period is log2_N+2 cycles: accept, log2_N SHIFT edges, DONE with out_ready=1, then back to IDLE. in_ready reasserts the cycle after the DONE handshake.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

## Configuration
- UNROT_SKIP_EN: early termination.
  - Defined: on any SHIFT edge where kreg has no set bit at indices above cnt, go to DONE immediately after applying the current stage.
  - Defined, at acceptance: if in_k==0, go straight from IDLE to DONE. out_valid rises after E0+1.
  - Defined, general case: latency = j+1 edges, where j is the highest index with k[j]=1.
  - Not defined: fixed latency of log2_N edges for every job.
- Data results are identical in both builds.

## Structure
- Package unrot_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a function giving stage shift = N>>(s+1).
- Sub-module unrot_step: combinational single-stage conditional left rotate.
  - Inputs: data, stage index, enable. Output: next data.
  - Built as a log2_N-way constant-rotate mux.
- Top-level: FSM, counter, registers and handshake.

## Test plan
All scenarios use N=8, log2_N=3; vectors are written index 0 leftmost.
- Reset, then hold: in_ready=1, out_valid=0, out_bits=8'b0.
- in_bits=8'b1000_0000, k=3'b001 → out_bits=8'b0000_0001.
  - Base build: out_valid after E0+3.
  - SKIP build: out_valid after E0+3, since j=2.
- in_bits=8'b1100_0000, k=3'b100 → out_bits=8'b0000_1100.
  - SKIP build: out_valid after E0+1.
  - Base build: out_valid after E0+3.
- k=0, in_bits=8'b1010_0110 → out_bits unchanged.
  - Base latency 3; SKIP latency 1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE, then pulse 1.
  - out_bits is stable throughout.
  - in_valid pulses while busy are dropped.
  - One result is delivered.
- Random round trip: all 8 k values × random words through the rotator then unrot_seq → equal to the original. Then assert rst_n low during SHIFT → outputs return to reset values and the next job completes correctly.

Source files
------------

// File: rtl/unrot_pkg.sv
// unrot_pkg: shared types and helpers for the sequential un-rotator.
//   state_t      : FSM state encoding (IDLE, SHIFT, DONE).
//   stage_shift  : constant left-rotate amount applied by stage s of an
//                  n-bit word (n >> (s+1)); stage 0 carries the MSB of k.
package unrot_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int stage_shift(input int n, input int s);
        return n >> (s + 1);
    endfunction

endpackage

// File: rtl/unrot_step.sv
// unrot_step: combinational single-stage conditional left rotate.
// Every stage's rotate is hard-wired, so the stage index only steers a mux.
// Ports:
//   data_in  [0:N-1]     current word, index 0 leftmost
//   stage    [CNT_W-1:0] stage index selecting the constant rotate amount
//   en                   apply the rotate; otherwise pass data_in through
//   data_out [0:N-1]     next word
module unrot_step
    import unrot_pkg::*;
#(
    parameter int N      = 512,
    parameter int LOG2_N = 9,
    parameter int CNT_W  = $clog2(LOG2_N + 1)
) (
    input  logic [0:N-1]     data_in,
    input  logic [CNT_W-1:0] stage,
    input  logic             en,
    output logic [0:N-1]     data_out
);

    logic [0:N-1] rot [LOG2_N];

    for (genvar s = 0; s < LOG2_N; s++) begin : g_stage
        for (genvar i = 0; i < N; i++) begin : g_bit
            // Left rotate: out[i] = in[(i + shift) mod N], resolved at elaboration.
            assign rot[s][i] = data_in[(i + stage_shift(N, s)) % N];
        end
    end

    always_comb begin
        data_out = data_in;
        if (en) begin
            for (int s = 0; s < LOG2_N; s++) begin
                if (stage == CNT_W'(s)) begin
                    data_out = rot[s];
                end
            end
        end
    end

endmodule

// File: rtl/unrot_seq.sv
// unrot_seq: sequential inverse of the barrel rotator. Rotates an N-bit word
// left by k, one binary stage per clock, with valid/ready on both sides.
// Optional build macro: UNROT_SKIP_EN -- finish as soon as no lower-weight
// bits of k remain (latency j+1, j = highest index with k[j]=1; 1 for k=0).
// Without it every job takes exactly LOG2_N SHIFT edges.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake (in_ready high only in IDLE)
//   in_bits [0:N-1]         word to un-rotate, index 0 leftmost
//   in_k    [0:LOG2_N-1]    rotate amount, k[0] is the MSB
//   out_valid / out_ready   output handshake (out_valid high only in DONE)
//   out_bits [0:N-1]        un-rotated word (always driven from data)
//
// state   | meaning
// S_IDLE  | waiting for a job, in_ready=1
// S_SHIFT | applying stage cnt of the rotate each edge
// S_DONE  | result held on out_bits, out_valid=1 until out_ready
module unrot_seq
    import unrot_pkg::*;
#(
    parameter int N      = 512,
    parameter int LOG2_N = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:N-1]      in_bits,
    input  logic [0:LOG2_N-1] in_k,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:N-1]      out_bits
);

    localparam int CNT_W = $clog2(LOG2_N + 1);
    localparam logic [CNT_W-1:0] LAST_STAGE = CNT_W'(LOG2_N - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [0:N-1]        data_q, data_d;
    logic [0:LOG2_N-1]   kreg_q, kreg_d;

    logic                step_en;
    logic [0:N-1]        step_out;
    logic                last_stage;

    unrot_step #(
        .N      (N),
        .LOG2_N (LOG2_N),
        .CNT_W  (CNT_W)
    ) u_step (
        .data_in  (data_q),
        .stage    (cnt_q),
        .en       (step_en),
        .data_out (step_out)
    );

`ifdef UNROT_SKIP_EN
    logic rest_set;

    // Any set bit of lower weight than the current stage still needs work.
    always_comb begin
        rest_set = 1'b0;
        for (int j = 0; j < LOG2_N; j++) begin
            if (CNT_W'(j) > cnt_q) begin
                rest_set = rest_set | kreg_q[j];
            end
        end
    end

    assign last_stage = (cnt_q == LAST_STAGE) || !rest_set;
`else
    assign last_stage = (cnt_q == LAST_STAGE);
`endif

    assign step_en   = (state_q == S_SHIFT) && kreg_q[cnt_q];
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_bits  = data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        kreg_d  = kreg_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d  = in_bits;
                    kreg_d  = in_k;
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                data_d = step_out;
                if (last_stage) begin
                    // Park cnt at 0 so kreg is never indexed past its range.
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            kreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            kreg_q  <= kreg_d;
        end
    end

endmodule

// File: tb/tb_unrot_seq.sv
// tb_unrot_seq: self-checking bench for unrot_seq at N=8, LOG2_N=3.
// Table-driven directed vectors, a backpressure case, a rotator round trip
// over all k, and a reset abort during SHIFT. Expected words are queued at
// acceptance and popped at the output handshake.
module tb_unrot_seq;

    localparam int N = 8;
    localparam int L = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [0:N-1]  in_bits;
    logic [0:L-1]  in_k;
    logic          out_valid;
    logic          out_ready;
    logic [0:N-1]  out_bits;

    int n_cmp = 0;
    int n_bad = 0;

    logic [0:N-1] exp_q [$];

    typedef struct {
        logic [0:N-1] bits;
        logic [0:L-1] k;
        logic [0:N-1] exp_bits;
        int           lat_base;
        int           lat_skip;
        int           hold;
    } vec_t;

    vec_t vecs [4];

    unrot_seq #(.N(N), .LOG2_N(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_k      (in_k),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference rotator: out[i] = in[(i - k) mod N].
    function automatic logic [0:N-1] rotr(input logic [0:N-1] x, input int k);
        logic [0:N-1] y;
        for (int i = 0; i < N; i++) y[i] = x[(i - k + N) % N];
        return y;
    endfunction

    function automatic int model_lat(input logic [0:L-1] k);
`ifdef UNROT_SKIP_EN
        int last = 0;
        for (int j = 0; j < L; j++) if (k[j]) last = j;
        return last + 1;
`else
        return L;
`endif
    endfunction

    function automatic int pick_lat(input int base_lat, input int skip_lat);
`ifdef UNROT_SKIP_EN
        return skip_lat;
`else
        return base_lat;
`endif
    endfunction

    task automatic run_job(input logic [0:N-1] bits, input logic [0:L-1] k,
                           input logic [0:N-1] exp_bits, input int lat, input int hold);
        int           cyc;
        logic [0:N-1] held;
        logic [0:N-1] e;
        @(negedge clk);
        check("idle_ready", in_ready, 1);
        in_bits  = bits;
        in_k     = k;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp_bits);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, lat);
        held = out_bits;
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", out_valid, 1);
            check("hold_bits", out_bits, held);
            check("busy_ready", in_ready, 0);
            in_valid = h[0];
            in_bits  = 8'($urandom);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("done_valid", out_valid, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("out_bits", out_bits, e);
        end else begin
            check("queue_nonempty", 0, 1);
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_ready", in_ready, 1);
    endtask

    initial begin
        logic [0:N-1] w;
        logic [0:L-1] kk;

        vecs[0] = '{8'b1000_0000, 3'b001, 8'b0000_0001, 3, 3, 0};
        vecs[1] = '{8'b1100_0000, 3'b100, 8'b0000_1100, 3, 1, 0};
        vecs[2] = '{8'b1010_0110, 3'b000, 8'b1010_0110, 3, 1, 0};
        vecs[3] = '{8'b0110_0001, 3'b010, 8'b1000_0101, 3, 2, 5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bits   = '0;
        in_k      = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_in_ready", in_ready, 1);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_bits", out_bits, 0);
        end

        for (int v = 0; v < 4; v++) begin
            run_job(vecs[v].bits, vecs[v].k, vecs[v].exp_bits,
                    pick_lat(vecs[v].lat_base, vecs[v].lat_skip), vecs[v].hold);
        end
        check("queue_drained", exp_q.size(), 0);

        for (int k = 0; k < N; k++) begin
            w  = 8'($urandom);
            kk = 3'(k);
            run_job(rotr(w, k), kk, w, model_lat(kk), 0);
        end

        // Abort a job mid-SHIFT; nothing is queued for it.
        @(negedge clk);
        in_bits  = 8'b1111_0000;
        in_k     = 3'b111;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("abort_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_bits", out_bits, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_no_output", out_valid, 0);

        w = 8'b0011_0101;
        run_job(rotr(w, 5), 3'b101, w, model_lat(3'b101), 0);
        check("queue_final", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
